// File: rtl/count_req_arbiter.sv
// count_req_arbiter
//   Serializes NUM_REQ requesters onto one shared call counter while also
//   keeping a private call counter per requester. Each granted request bumps
//   both counters and returns a one-cycle response with the updated values.
//   Arbitration is round-robin, starting from the requester after the last
//   one served.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (dominates everything)
//   req          per-requester request level, held until ack
//   ack          one-hot, one-cycle pulse to the served requester
//   clr          synchronous clear of shared and private counters
//   resp_valid   one-cycle pulse, response fields valid
//   resp_id      index of the served requester
//   resp_shared  shared counter value after this increment
//   resp_local   served requester's private counter after this increment
//   busy         high while a transaction is in flight (GRANT/RESP)
module count_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  input  logic               clr,
  output logic               resp_valid,
  output logic [ID_W-1:0]    resp_id,
  output logic [CNT_W-1:0]   resp_shared,
  output logic [CNT_W-1:0]   resp_local,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_t;

  // One extra bit so rr_ptr + offset never overflows before the wrap compare.
  localparam int              IW        = ID_W + 1;
  localparam logic [IW-1:0]   NUM_REQ_W = IW'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [CNT_W-1:0]     shared_q, shared_d;
  logic [CNT_W-1:0]     priv_q [NUM_REQ];
  logic [CNT_W-1:0]     priv_d [NUM_REQ];
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;
  logic [CNT_W-1:0]     resp_shared_q, resp_shared_d;
  logic [CNT_W-1:0]     resp_local_q, resp_local_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [IW-1:0]        idx;
  logic [CNT_W-1:0]     shared_inc;
  logic [CNT_W-1:0]     local_inc;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    cur_id_d      = cur_id_q;
    shared_d      = shared_q;
    priv_d        = priv_q;
    ack_d         = '0;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_shared_d = resp_shared_q;
    resp_local_d  = resp_local_q;
    found         = 1'b0;
    idx           = '0;
    shared_inc    = shared_q + 1'b1;
    local_inc     = priv_q[cur_id_q] + 1'b1;

    case (state_q)
      S_IDLE: begin
        // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so that
        // non-power-of-two NUM_REQ never selects an index >= NUM_REQ.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          idx = {1'b0, rr_q} + IW'(i);
          if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
          if (!found && req[idx[ID_W-1:0]]) begin
            found    = 1'b1;
            cur_id_d = idx[ID_W-1:0];
          end
        end
        if (found) state_d = S_GRANT;
      end
      S_GRANT: begin
        shared_d           = shared_inc;
        priv_d[cur_id_q]   = local_inc;
        // Response is registered here so it is presented during RESP;
        // a coincident clr forces the reported values to zero as well.
        resp_shared_d      = clr ? '0 : shared_inc;
        resp_local_d       = clr ? '0 : local_inc;
        resp_id_d          = cur_id_q;
        resp_valid_d       = 1'b1;
        ack_d[cur_id_q]    = 1'b1;
        state_d            = S_RESP;
      end
      S_RESP: begin
        rr_d    = (cur_id_q == LAST_ID) ? '0 : cur_id_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clr) begin
      shared_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) priv_d[i] = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      cur_id_q      <= '0;
      shared_q      <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) priv_q[i] <= '0;
      ack_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_shared_q <= '0;
      resp_local_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      cur_id_q      <= cur_id_d;
      shared_q      <= shared_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) priv_q[i] <= priv_d[i];
      ack_q         <= ack_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_shared_q <= resp_shared_d;
      resp_local_q  <= resp_local_d;
      busy_q        <= busy_d;
    end
  end

  assign ack         = ack_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_shared = resp_shared_q;
  assign resp_local  = resp_local_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_count_req_arbiter.sv
// tb_count_req_arbiter
//   Scoreboard bench for count_req_arbiter. The driver issues one transaction
//   at a time, predicts the response from a round-robin / counter model and
//   pushes it; a monitor pops and compares whenever resp_valid is seen.
module tb_count_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int MODV    = 1 << CNT_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] ack;
  logic               clr = 1'b0;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic [CNT_W-1:0]   resp_shared;
  logic [CNT_W-1:0]   resp_local;
  logic               busy;

  count_req_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .clr(clr),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_shared(resp_shared),
    .resp_local(resp_local), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sh;
    int lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Reference model state
  int m_rr;
  int m_shared;
  int m_priv [NUM_REQ];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] p, input int rr);
    logic [NUM_REQ-1:0] t;
    for (int i = 0; i < NUM_REQ; i++) begin
      t = p >> ((rr + i) % NUM_REQ);
      if (t[0]) return (rr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0;
    m_shared = 0;
    for (int i = 0; i < NUM_REQ; i++) m_priv[i] = 0;
  endtask

  // Monitor: compare every presented response against the scoreboard.
  initial begin
    exp_t e;
    logic [NUM_REQ-1:0] onehot;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          onehot = '0;
          onehot[e.id] = 1'b1;
          check("resp_id", 32'(resp_id), e.id);
          check("resp_shared", 32'(resp_shared), e.sh);
          check("resp_local", 32'(resp_local), e.lc);
          check("ack_onehot", 32'(ack), 32'(onehot));
          check("busy_in_resp", 32'(busy), 32'd1);
        end
      end else if (ack !== '0) begin
        check("stray_ack", 32'(ack), 32'd0);
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One transaction: predict, push, drive, optionally drop req or pulse clr
  // during GRANT (first cycle busy is seen), then wait for the response.
  task automatic do_txn(input logic [NUM_REQ-1:0] pat, input bit drop,
                        input bit do_clr, output int lat);
    exp_t e;
    bit acted;
    int w;
    w = pick(pat, m_rr);
    m_shared = (m_shared + 1) % MODV;
    m_priv[w] = (m_priv[w] + 1) % MODV;
    if (do_clr) begin
      m_shared = 0;
      for (int i = 0; i < NUM_REQ; i++) m_priv[i] = 0;
    end
    e.id = w;
    e.sh = m_shared;
    e.lc = m_priv[w];
    m_rr = (w + 1) % NUM_REQ;
    exp_q.push_back(e);
    req = pat;
    lat = 0;
    acted = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      lat++;
      if (exp_q.size() == 0) break;
      if (lat > 12) begin
        check("resp_timeout", 32'(lat), 32'd3);
        exp_q.delete();
        break;
      end
      if (busy && !acted) begin
        acted = 1'b1;
        if (drop) req = '0;
        if (do_clr) clr = 1'b1;
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    int lat;
    logic [NUM_REQ-1:0] pat;
    model_reset();

    // Reset state
    reset_dut();
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_shared", 32'(resp_shared), 32'd0);
    check("rst_resp_local", 32'(resp_local), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single requester held: first response 2 cycles after req, then every 3
    do_txn(4'b0001, 0, 0, lat);
    check("latency_first", 32'(lat), 32'd2);
    do_txn(4'b0001, 0, 0, lat);
    check("latency_b2b", 32'(lat), 32'd3);
    do_txn(4'b0001, 0, 0, lat);
    check("latency_b2b", 32'(lat), 32'd3);

    // All requesting: round-robin 0,1,2,3,0,1,2,3
    reset_dut();
    for (int i = 0; i < 8; i++) do_txn(4'b1111, 0, 0, lat);

    // Alternate req0 / req2: shared vs private separation
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      do_txn(4'b0001, 0, 0, lat);
      do_txn(4'b0100, 0, 0, lat);
    end

    // 256 transactions on req0: wrap to 0 on the 256th
    reset_dut();
    for (int i = 0; i < 256; i++) do_txn(4'b0001, 0, 0, lat);

    // clr during GRANT after 5 transactions, then 1/1
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      pat = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      do_txn(pat, 0, 0, lat);
    end
    do_txn(4'b0010, 0, 1, lat);
    do_txn(4'b0010, 0, 0, lat);

    // Requester drops req during GRANT: still completes
    do_txn(4'b0100, 1, 0, lat);

    // rst during GRANT: no response, everything back to zero
    req = 4'b0100;
    lat = 0;
    while (!busy && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("grant_seen", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_shared", 32'(resp_shared), 32'd0);
    check("midrst_resp_local", 32'(resp_local), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req = '0;
    model_reset();
    do_txn(4'b1000, 0, 0, lat);

    // Random traffic with occasional drops and clears
    for (int i = 0; i < 150; i++) begin
      pat = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      do_txn(pat, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), lat);
    end

    req = '0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
